// File: rtl/sha1_multiblock_engine.sv
// SHA-1 compression engine behind a word-addressed register port; hashes one padded
// 512-bit block per START, optionally chaining from the previous digest.
module sha1_multiblock_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        write,
  input  logic        read,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int CYCLES = 80 / ROUNDS_PER_CYCLE;
  localparam logic [6:0] LAST_T = 7'((CYCLES - 1) * ROUNDS_PER_CYCLE);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_PROC  = 2'd2;
  localparam logic [1:0] ST_FINAL = 2'd3;
  localparam logic [159:0] IV = {32'h67452301, 32'hEFCDAB89, 32'h98BADCFE,
                                 32'h10325476, 32'hC3D2E1F0};

  generate
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 5)) begin : g_bad_rounds
      $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 5");
    end
  endgenerate

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // R rounds from one state; R divides 20 so f/K follow the first round index
  function automatic logic [159:0] rounds_fn(input logic [159:0] st, input logic [511:0] win,
                                             input logic [6:0] t);
    logic [31:0] a, b, c, d, e, f, k, tmp;
    {a, b, c, d, e} = st;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      if (t < 7'd20) begin
        f = (b & c) | (~b & d);
        k = 32'h5A827999;
      end else if (t < 7'd40) begin
        f = b ^ c ^ d;
        k = 32'h6ED9EBA1;
      end else if (t < 7'd60) begin
        f = (b & c) | (b & d) | (c & d);
        k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d;
        k = 32'hCA62C1D6;
      end
      tmp = rotl(a, 5) + f + e + k + win[32*j +: 32];
      e = d;
      d = c;
      c = rotl(b, 30);
      b = a;
      a = tmp;
    end
    return {a, b, c, d, e};
  endfunction

  // new words may depend on words produced earlier in the same cycle
  function automatic logic [511:0] expand_fn(input logic [511:0] win);
    logic [32*(16+ROUNDS_PER_CYCLE)-1:0] ext;
    ext = {{(32*ROUNDS_PER_CYCLE){1'b0}}, win};
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++)
      ext[32*(16+k) +: 32] = rotl(ext[32*(13+k) +: 32] ^ ext[32*(8+k) +: 32] ^
                                  ext[32*(2+k) +: 32] ^ ext[32*k +: 32], 1);
    return ext[32*(16+ROUNDS_PER_CYCLE)-1 -: 512];
  endfunction

  logic [1:0]   state_r;
  logic         ctrl_chain_r, ctrl_irq_en_r, chain_lat_r, done_r, err_r;
  logic [15:0]  blkcnt_r;
  logic [31:0]  h_in_r   [0:4];
  logic [31:0]  m_r      [0:15];
  logic [31:0]  digest_r [0:4];
  logic [159:0] st_r;
  logic [511:0] window_r;
  logic [6:0]   t_r;
  logic         busy_s, start_s;
  logic [159:0] init_s;
  logic [511:0] m_flat_s;
  logic [31:0]  rd_s;

  assign busy_s   = (state_r != ST_IDLE);
  assign start_s  = write && (address == 6'd0) && writedata[0] && !busy_s;
  assign irq      = done_r & ctrl_irq_en_r;
  assign readdata = rd_s;

  // Chaining initial state and flattened message for LOAD
  always_comb begin
    init_s   = 160'd0;
    m_flat_s = 512'd0;
    for (int i = 0; i < 5; i++)
      init_s[159-32*i -: 32] = chain_lat_r ? digest_r[i] : h_in_r[i];
    for (int i = 0; i < 16; i++)
      m_flat_s[32*i +: 32] = m_r[i];
  end

  // Register read mux, zero when not reading
  always_comb begin
    rd_s = 32'd0;
    if (read) begin
      case (address) inside
        6'd0:          rd_s = {29'd0, ctrl_irq_en_r, ctrl_chain_r, 1'b0};
        6'd1:          rd_s = {blkcnt_r, 13'd0, err_r, busy_s, done_r};
        [6'd2:6'd6]:   rd_s = h_in_r[3'(address - 6'd2)];
        [6'd7:6'd22]:  rd_s = m_r[4'(address - 6'd7)];
        [6'd23:6'd27]: rd_s = digest_r[3'(address - 6'd23)];
        default:       rd_s = 32'd0;
      endcase
    end else begin
      rd_s = 32'd0;
    end
  end

  // Register writes and the LOAD/PROC/FINAL sequencer; FINAL is last so its DONE set wins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      ctrl_chain_r  <= 1'b0;
      ctrl_irq_en_r <= 1'b0;
      chain_lat_r   <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      blkcnt_r      <= 16'd0;
      st_r          <= 160'd0;
      window_r      <= 512'd0;
      t_r           <= 7'd0;
      for (int i = 0; i < 5; i++) begin
        h_in_r[i]   <= IV[159-32*i -: 32];
        digest_r[i] <= 32'd0;
      end
      for (int i = 0; i < 16; i++) m_r[i] <= 32'd0;
    end else begin
      if (write) begin
        case (address) inside
          6'd0: begin
            if (writedata[0] && busy_s) begin
              err_r <= 1'b1;
            end else begin
              ctrl_chain_r  <= writedata[1];
              ctrl_irq_en_r <= writedata[2];
            end
          end
          6'd1: begin
            if (writedata[0]) done_r <= 1'b0;
            if (writedata[2]) err_r <= 1'b0;
          end
          [6'd2:6'd6]: begin
            if (busy_s) err_r <= 1'b1;
            else h_in_r[3'(address - 6'd2)] <= writedata;
          end
          [6'd7:6'd22]: begin
            if (busy_s) err_r <= 1'b1;
            else m_r[4'(address - 6'd7)] <= writedata;
          end
          default: ;
        endcase
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r     <= ST_LOAD;
            done_r      <= 1'b0;
            chain_lat_r <= writedata[1];
          end
        end
        ST_LOAD: begin
          st_r     <= init_s;
          window_r <= m_flat_s;
          t_r      <= 7'd0;
          state_r  <= ST_PROC;
        end
        ST_PROC: begin
          st_r     <= rounds_fn(st_r, window_r, t_r);
          window_r <= expand_fn(window_r);
          t_r      <= t_r + 7'(ROUNDS_PER_CYCLE);
          if (t_r == LAST_T) state_r <= ST_FINAL;
        end
        ST_FINAL: begin
          for (int i = 0; i < 5; i++)
            digest_r[i] <= init_s[159-32*i -: 32] + st_r[159-32*i -: 32];
          done_r   <= 1'b1;
          blkcnt_r <= blkcnt_r + 16'd1;
          state_r  <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha1_multiblock_engine.sv
// Directed bench: three engine instances (R=1, 4, 5) driven over a shared register bus,
// checked against published SHA-1 digests and hand-counted latencies.
module tb_sha1_multiblock_engine;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        read;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [2:0]  write_v;
  logic [31:0] rdata [3];
  logic [2:0]  irq_v;
  logic [31:0] msg [16];
  logic [31:0] rv;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sha1_multiblock_engine #(.ROUNDS_PER_CYCLE(1)) u_r1 (
    .clk(clk), .reset_n(reset_n), .write(write_v[0]), .read(read), .address(address),
    .writedata(writedata), .readdata(rdata[0]), .irq(irq_v[0]));
  sha1_multiblock_engine #(.ROUNDS_PER_CYCLE(4)) u_r4 (
    .clk(clk), .reset_n(reset_n), .write(write_v[1]), .read(read), .address(address),
    .writedata(writedata), .readdata(rdata[1]), .irq(irq_v[1]));
  sha1_multiblock_engine #(.ROUNDS_PER_CYCLE(5)) u_r5 (
    .clk(clk), .reset_n(reset_n), .write(write_v[2]), .read(read), .address(address),
    .writedata(writedata), .readdata(rdata[2]), .irq(irq_v[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input int inst, input logic [5:0] addr, input logic [31:0] data);
    address = addr;
    writedata = data;
    write_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    write_v = 3'd0;
  endtask

  task automatic bus_rd(input int inst, input logic [5:0] addr, output logic [31:0] data);
    address = addr;
    read = 1'b1;
    #1;
    data = rdata[inst];
    read = 1'b0;
  endtask

  task automatic load_msg(input int inst);
    for (int i = 0; i < 16; i++) bus_wr(inst, 6'(7 + i), msg[i]);
  endtask

  task automatic check_reg(input int inst, input logic [5:0] addr, input string tag,
                           input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(inst, addr, v);
    check_val(tag, v, exp);
  endtask

  task automatic check_digest(input int inst, input string tag, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [31:0] e4);
    check_reg(inst, 6'd23, {tag, "_d0"}, e0);
    check_reg(inst, 6'd24, {tag, "_d1"}, e1);
    check_reg(inst, 6'd25, {tag, "_d2"}, e2);
    check_reg(inst, 6'd26, {tag, "_d3"}, e3);
    check_reg(inst, 6'd27, {tag, "_d4"}, e4);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
  endtask

  initial begin
    reset_n = 1'b0;
    read = 1'b0;
    write_v = 3'd0;
    address = 6'd0;
    writedata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // reset state
    address = 6'd2;
    #1;
    check_val("rst_rd_idle", rdata[0], 32'd0);
    check_reg(0, 6'd0, "rst_ctrl", 32'd0);
    check_reg(0, 6'd1, "rst_status", 32'd0);
    check_reg(0, 6'd2, "rst_hin0", 32'h67452301);
    check_reg(0, 6'd3, "rst_hin1", 32'hEFCDAB89);
    check_reg(0, 6'd4, "rst_hin2", 32'h98BADCFE);
    check_reg(0, 6'd5, "rst_hin3", 32'h10325476);
    check_reg(0, 6'd6, "rst_hin4", 32'hC3D2E1F0);
    check_reg(0, 6'd7, "rst_m0", 32'd0);
    check_reg(0, 6'd23, "rst_dig0", 32'd0);
    check_val("rst_irq", {29'd0, irq_v}, 32'd0);

    // "abc" with R=1: DONE lands on edge T+82
    set_abc();
    load_msg(0);
    bus_wr(0, 6'd0, 32'd1);
    tick(1);
    check_reg(0, 6'd1, "t1_busy_T1", 32'h0000_0002);
    tick(80);
    check_reg(0, 6'd1, "t1_stat_T81", 32'h0000_0002);
    tick(1);
    check_reg(0, 6'd1, "t1_stat_T82", 32'h0001_0001);
    check_digest(0, "t1", 32'hA9993E36, 32'h4706816A, 32'hBA3E2571, 32'h7850C26C, 32'h9CD0D89D);

    // writes to M and START while busy are rejected
    bus_wr(0, 6'd0, 32'd1);
    tick(5);
    bus_wr(0, 6'd7, 32'hFFFFFFFF);
    bus_wr(0, 6'd0, 32'd1);
    tick(74);
    check_reg(0, 6'd1, "t4_stat_T81", 32'h0001_0006);
    tick(1);
    check_reg(0, 6'd1, "t4_stat_T82", 32'h0002_0005);
    check_digest(0, "t4", 32'hA9993E36, 32'h4706816A, 32'hBA3E2571, 32'h7850C26C, 32'h9CD0D89D);
    check_reg(0, 6'd7, "t4_m0", 32'h61626380);
    bus_wr(0, 6'd1, 32'd1);
    tick(90);
    check_reg(0, 6'd1, "t4_one_done", 32'h0002_0004);
    bus_wr(0, 6'd1, 32'd4);
    check_reg(0, 6'd1, "t4_err_w1c", 32'h0002_0000);

    // two-block message with chaining, R=4
    msg[0] = 32'h61626364; msg[1] = 32'h62636465; msg[2] = 32'h63646566;
    msg[3] = 32'h64656667; msg[4] = 32'h65666768; msg[5] = 32'h66676869;
    msg[6] = 32'h6768696A; msg[7] = 32'h68696A6B; msg[8] = 32'h696A6B6C;
    msg[9] = 32'h6A6B6C6D; msg[10] = 32'h6B6C6D6E; msg[11] = 32'h6C6D6E6F;
    msg[12] = 32'h6D6E6F70; msg[13] = 32'h6E6F7071; msg[14] = 32'h80000000;
    msg[15] = 32'h00000000;
    load_msg(1);
    bus_wr(1, 6'd0, 32'd1);
    tick(21);
    check_reg(1, 6'd1, "t2_b1_T21", 32'h0000_0002);
    tick(1);
    check_reg(1, 6'd1, "t2_b1_T22", 32'h0001_0001);
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[15] = 32'h000001C0;
    load_msg(1);
    bus_wr(1, 6'd0, 32'd3);
    bus_wr(1, 6'd0, 32'd0);
    check_reg(1, 6'd0, "t2_ctrl_upd", 32'd0);
    tick(20);
    check_reg(1, 6'd1, "t2_b2_T21", 32'h0001_0002);
    tick(1);
    check_reg(1, 6'd1, "t2_b2_T22", 32'h0002_0001);
    check_digest(1, "t2", 32'h84983E44, 32'h1C3BD26E, 32'hBAAE4AA1, 32'hF95129E5, 32'hE54670F1);
    bus_wr(1, 6'd23, 32'd0);
    check_reg(1, 6'd23, "t2_dig_ro", 32'h84983E44);

    // empty message, R=5, interrupt
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0] = 32'h80000000;
    load_msg(2);
    bus_wr(2, 6'd0, 32'd4);
    bus_wr(2, 6'd0, 32'd5);
    tick(17);
    check_val("t3_irq_T17", {31'd0, irq_v[2]}, 32'd0);
    tick(1);
    check_val("t3_irq_T18", {31'd0, irq_v[2]}, 32'd1);
    check_digest(2, "t3", 32'hDA39A3EE, 32'h5E6B4B0D, 32'h3255BFEF, 32'h95601890, 32'hAFD80709);
    bus_wr(2, 6'd1, 32'd1);
    check_val("t3_irq_clr", {31'd0, irq_v[2]}, 32'd0);

    // W1C of DONE and ERR on the FINAL edge
    bus_wr(2, 6'd0, 32'd1);
    bus_wr(2, 6'd2, 32'h12345678);
    tick(16);
    check_reg(2, 6'd1, "t6_err_set", 32'h0001_0006);
    bus_wr(2, 6'd1, 32'd5);
    check_reg(2, 6'd1, "t6_set_wins", 32'h0002_0001);
    check_reg(2, 6'd2, "t6_hin0", 32'h67452301);
    check_reg(2, 6'd23, "t6_dig0", 32'hDA39A3EE);
    check_reg(2, 6'd40, "t6_unmapped", 32'd0);

    // reset in the middle of PROC, then a fresh run
    bus_wr(0, 6'd0, 32'd5);
    tick(41);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_reg(0, 6'd1, "t5_status", 32'd0);
    check_reg(0, 6'd23, "t5_dig0", 32'd0);
    check_reg(0, 6'd2, "t5_hin0", 32'h67452301);
    check_reg(0, 6'd7, "t5_m0", 32'd0);
    check_reg(0, 6'd0, "t5_ctrl", 32'd0);
    check_val("t5_irq", {31'd0, irq_v[0]}, 32'd0);
    set_abc();
    load_msg(0);
    bus_wr(0, 6'd0, 32'd1);
    tick(82);
    check_reg(0, 6'd1, "t5_rerun_stat", 32'h0001_0001);
    check_digest(0, "t5", 32'hA9993E36, 32'h4706816A, 32'hBA3E2571, 32'h7850C26C, 32'h9CD0D89D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
